// File: rtl/car_sense_cond_if.sv
// ============================================================================
// Module      : car_sense_cond_if
// Description : Sensor-to-controller bundle for car_sense_cond: raw switches,
//               service pulses, conditioned requests and arrival counts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface car_sense_cond_if #(
    parameter int CW = 4
);
    logic [1:0]    SW_RAW;
    logic [1:0]    SERVED;
    logic [1:0]    REQ;
    logic [1:0]    ARRIVE;
    logic [CW-1:0] CNT_N;
    logic [CW-1:0] CNT_E;

    modport master (
        output SW_RAW, SERVED,
        input  REQ, ARRIVE, CNT_N, CNT_E
    );

    modport slave (
        input  SW_RAW, SERVED,
        output REQ, ARRIVE, CNT_N, CNT_E
    );
endinterface

`default_nettype wire

// File: rtl/car_sense_cond.sv
// ============================================================================
// Module      : car_sense_cond
// Description : Two-channel car-sensor synchronizer/debouncer with request
//               latching (CAR_REQ_LATCH_EN) and saturating arrival counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module car_sense_cond #(
    parameter int DEB_CNT = 50000,
    parameter int CW      = 4
) (
    input  wire               CLOCK_50,
    input  wire               RESET,
    car_sense_cond_if.slave   bus
);
    localparam int              c_DW       = $clog2(DEB_CNT + 1);
    localparam logic [c_DW-1:0] c_DEB_LAST = c_DW'(DEB_CNT - 1);
    localparam logic [CW-1:0]   c_CNT_MAX  = {CW{1'b1}};

    logic [1:0]    w_req;
    logic [1:0]    w_arrive;
    logic [CW-1:0] w_cnt [2];

    for (genvar i = 0; i < 2; i++) begin : g_chan
        logic            r_s1;
        logic            r_s2;
        logic            r_deb;
        logic            r_deb_d;
        logic [c_DW-1:0] r_dcnt;
        logic            r_req;
        logic            r_arrive;
        logic [CW-1:0]   r_cnt;
        logic            w_rise;

        // Debounced level rose on the previous edge
        assign w_rise = r_deb & ~r_deb_d;

        always_ff @(posedge CLOCK_50) begin
            if (RESET) begin
                r_s1     <= 1'b0;
                r_s2     <= 1'b0;
                r_deb    <= 1'b0;
                r_deb_d  <= 1'b0;
                r_dcnt   <= '0;
                r_req    <= 1'b0;
                r_arrive <= 1'b0;
                r_cnt    <= '0;
            end else begin
                r_s1 <= bus.SW_RAW[i];
                r_s2 <= r_s1;

                if (r_s2 == r_deb) begin
                    r_dcnt <= '0;
                end else if (r_dcnt == c_DEB_LAST) begin
                    r_deb  <= r_s2;
                    r_dcnt <= '0;
                end else begin
                    r_dcnt <= r_dcnt + c_DW'(1);
                end

                r_deb_d  <= r_deb;
                r_arrive <= w_rise;

`ifdef CAR_REQ_LATCH_EN
                r_req <= r_deb | (r_req & ~bus.SERVED[i]);
`else
                r_req <= r_deb;
`endif

                // Service wins over counting, but a coincident arrival still counts once
                if (bus.SERVED[i]) begin
                    r_cnt <= CW'(w_rise);
                end else if (w_rise && (r_cnt != c_CNT_MAX)) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end

        assign w_req[i]    = r_req;
        assign w_arrive[i] = r_arrive;
        assign w_cnt[i]    = r_cnt;
    end

    assign bus.REQ    = w_req;
    assign bus.ARRIVE = w_arrive;
    assign bus.CNT_N  = w_cnt[0];
    assign bus.CNT_E  = w_cnt[1];

endmodule

`default_nettype wire

// File: doc/car_sense_cond.md
# car_sense_cond

Sensor-conditioning stage directly upstream of the traffic light controller. Takes the two raw car-sensor switches (bit 0 = North, bit 1 = East) and synchronizes and debounces each one. Turns them into clean per-direction request levels that drive the controller's `SW` inputs. Also keeps a saturating count of arrivals per direction since that direction was last served, for the display/diagnostic path.

## Interface
- `DEB_CNT`, default 50000: number of consecutive clocks a synchronized input must differ from the debounced value before the debounced value flips. Legal range is ≥1.
- `CW`, default 4: width of each arrival counter.
- `CLOCK_50`  in  1: system clock; all logic on its rising edge.
- `RESET`  in  1: synchronous, active-high reset.
- `SW_RAW`  in  2: raw asynchronous sensor inputs, [0]=North, [1]=East.
- `SERVED`  in  2: one-cycle pulse from the controller when a direction enters green.
- `REQ`  out  2: conditioned request to the controller's `SW`.
- `ARRIVE`  out  2: one-cycle pulse per debounced rising edge.
- `CNT_N`  out  CW: North arrivals since last North service.
- `CNT_E`  out  CW: East arrivals since last East service.

## Operation
- Each channel is independent and identical.
- **Synchronizer:** two flops, `s1` then `s2`.
- **Debouncer:** per-channel counter of width clog2(DEB_CNT+1) and a debounced flop `deb`.
  - If `s2 == deb`, the counter clears.
  - Otherwise the counter increments. When it reaches DEB_CNT−1 with `s2` still differing, `deb <= s2` and the counter clears.
  - Any glitch shorter than DEB_CNT clocks leaves `deb` unchanged and restarts the count.
- **Arrival:** `ARRIVE[i]` is a registered pulse, high for one cycle when `deb[i]` goes 0→1.
- **Request, with latching enabled:**
  - `REQ[i]` next = `deb[i]` | (`REQ[i]` & ~`SERVED[i]`).
  - A car that has left still holds the request until it is served.
  - A `SERVED` pulse while `deb` is high leaves `REQ` at 1.
- **Arrival counter:**
  - Increments on `ARRIVE` and saturates at 2^CW−1; it never wraps.
  - `SERVED[i]` clears it to 0.
  - If `SERVED` and `ARRIVE` occur in the same cycle, the next value is 1.
- **Reset:** while `RESET` is high at a clock edge, all of `s1`, `s2`, `deb`, the debounce counters, `REQ`, `ARRIVE`, `CNT_N` and `CNT_E` go to 0.
  - Reset mid-debounce discards the partial count.
  - After release, a still-high sensor needs the full 2+DEB_CNT clocks to reassert `REQ`.

## Timing
- `SW_RAW[i]` changes before edge k and is stable from then on.
- `s2` updates at edge k+1.
- `deb` updates at edge k+1+DEB_CNT.
- `REQ`, `ARRIVE` and the counter update at edge k+2+DEB_CNT.
- Total latency is DEB_CNT+2 clocks.
- `SERVED` sampled at edge j takes effect on `REQ` and the counter at edge j, i.e. visible after that edge.
- `REQ` falls one clock after `SERVED` if `deb` is low.
- All outputs are registered; no combinational path from input to output.

## Configuration
- `CAR_REQ_LATCH_EN` defined: `REQ` latches as described in Operation.
- Not defined: `REQ` = registered `deb`, i.e. the pure debounced level. `SERVED` then affects only the counters.
- `ARRIVE` and the counters behave identically in both builds.

## Test plan
All scenarios use DEB_CNT=4 and CW=4.
- **Reset:** assert `RESET` with `SW_RAW`=2'b11 → all outputs 0 at the first edge. Release at edge r → `REQ`=2'b11 and `ARRIVE`=2'b11 for one cycle at edge r+6; `CNT_N`=`CNT_E`=1.
- **Glitch rejection:** pulse `SW_RAW[0]` high for 3 clocks → `REQ`, `ARRIVE` and `CNT_N` stay 0 throughout. A 4-clock pulse → `ARRIVE[0]` pulses and `CNT_N`=1.
- **Latching:** raise `SW_RAW[1]` for 10 clocks then drop it → `REQ[1]` stays 1 until a `SERVED[1]` pulse, then 0 the next clock. Without the macro, `REQ[1]` follows `deb` and falls 6 clocks after `SW_RAW[1]` drops.
- **Served while present:** keep `SW_RAW[0]` high and pulse `SERVED[0]` → `REQ[0]` remains 1 and `CNT_N` clears to 0.
- **Saturation:** produce 17 clean North arrivals with no service → `CNT_N` reads 15 after the 15th and stays 15. Then `SERVED[0]` → 0.
- **Simultaneous events:** align `SERVED[1]` with an East `ARRIVE` → `CNT_E`=1 and `REQ[1]`=1. North is unaffected throughout.
